mem_interface: RTL and testbench

MEM_INTERFACE -- requirements
Module: mem_interface

---
 rtl/mem_interface_pkg.sv | 13 +
 rtl/mem_interface_timeout_counter.sv | 37 +++
 rtl/mem_interface.sv | 129 ++++++++++++
 tb/tb_mem_interface.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_interface_pkg.sv
// Shared definitions for the memory interface: state encoding and parameter defaults.
package mem_interface_pkg;

  localparam int ADDR_W_DEF  = 9;
  localparam int TIMEOUT_DEF = 15;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_REQ  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/mem_interface_timeout_counter.sv
// Request-phase cycle counter; tc flags the last cycle a request may wait for an ack.
module timeout_counter
  import mem_interface_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic clr,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_interface.sv
// MAR/MDR register pair with a request/ack RAM handshake, timeout abort and sticky error.
module mem_interface
  import mem_interface_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [31:0]       bus_mux_out,
  input  logic              mar_in,
  input  logic              mdr_in,
  input  logic              mem_rd,
  input  logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_req,
  output logic              mem_we,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic [31:0]       mdr_out,
  output logic [31:0]       mar_out,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [31:0]       mdr_q, mdr_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              cnt_clear, cnt_en, tc;

  timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk    (clk),
    .clr    (clr),
    .clear  (cnt_clear),
    .enable (cnt_en),
    .tc     (tc)
  );

  always_comb begin
    state_d   = state_q;
    mar_d     = mar_q;
    mdr_d     = mdr_q;
    req_d     = req_q;
    we_d      = we_q;
    done_d    = 1'b0;
    err_d     = err_q;
    cnt_clear = 1'b0;
    cnt_en    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mar_in) mar_d = bus_mux_out[ADDR_W-1:0];
        if (mdr_in) mdr_d = bus_mux_out;
        if (mem_rd || mem_wr) begin
          state_d   = ST_REQ;
          req_d     = 1'b1;
          we_d      = mem_wr && !mem_rd;
          err_d     = 1'b0;
          cnt_clear = 1'b1;
        end
      end
      ST_REQ: begin
        // Ack is checked first so an ack on the terminal cycle still succeeds.
        if (mem_ack) begin
          if (!we_q) mdr_d = mem_rdata;
          state_d = ST_DONE;
          req_d   = 1'b0;
          we_d    = 1'b0;
        end else if (tc) begin
          state_d = ST_IDLE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          err_d   = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
        we_d    = 1'b0;
      end
    endcase
    busy_d = (state_d == ST_REQ) || (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q <= ST_IDLE;
      mar_q   <= '0;
      mdr_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      req_q   <= req_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign mem_addr  = mar_q;
  assign mem_wdata = mdr_q;
  assign mdr_out   = mdr_q;
  assign mar_out   = {{(32-ADDR_W){1'b0}}, mar_q};
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_interface.sv
// Randomized scoreboard bench for mem_interface against a transaction-level reference model.
module tb_mem_interface;

  localparam int AW = 9;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          clr;
  logic [31:0]   bus_mux_out;
  logic          mar_in, mdr_in, mem_rd, mem_wr;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_req, mem_we;
  logic [31:0]   mem_rdata;
  logic          mem_ack;
  logic [31:0]   mdr_out, mar_out;
  logic          busy, done, err;

  mem_interface #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .clr(clr), .bus_mux_out(bus_mux_out),
    .mar_in(mar_in), .mdr_in(mdr_in), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_req(mem_req), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mdr_out(mdr_out), .mar_out(mar_out),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic          we;
    logic [31:0]   wdata;
  } req_t;

  typedef struct {
    int          cycles;
    logic        ok;
    logic        err;
    logic        busy;
    logic [31:0] mdr;
  } out_t;

  req_t exp_req[$];
  out_t exp_out[$];

  int tests = 0;
  int fails = 0;

  // Reference state of the programmer-visible registers
  logic [AW-1:0] ref_mar;
  logic [31:0]   ref_mdr;
  logic          ref_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic quiet;
    mar_in = 1'b0; mdr_in = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
  endtask

  // mode 0: nothing, 1: random control noise, 2: try to load MAR with 0x0AA
  task automatic noise(input int mode);
    if (mode == 1) begin
      bus_mux_out = $urandom;
      mar_in = 1'($urandom); mdr_in = 1'($urandom);
      mem_rd = 1'($urandom); mem_wr = 1'($urandom);
    end else if (mode == 2) begin
      bus_mux_out = 32'h0000_00AA;
      mar_in = 1'b1;
    end
  endtask

  // d < TO: ack arrives on REQ cycle d (0 = first); d >= TO: never acked
  task automatic txn(input bit lmar, input bit lmdr, input bit rd, input bit wr,
                     input logic [31:0] bus, input int d, input logic [31:0] rdata,
                     input int nmode);
    req_t r;
    out_t o;
    bus_mux_out = bus;
    mar_in = lmar; mdr_in = lmdr; mem_rd = rd; mem_wr = wr;
    if (lmar) ref_mar = bus[AW-1:0];
    if (lmdr) ref_mdr = bus;
    r.addr = ref_mar; r.we = !rd; r.wdata = ref_mdr;
    exp_req.push_back(r);
    if (d < TO) begin
      if (rd) ref_mdr = rdata;
      ref_err = 1'b0;
      o.cycles = d + 1; o.ok = 1'b1; o.busy = 1'b1;
    end else begin
      ref_err = 1'b1;
      o.cycles = TO; o.ok = 1'b0; o.busy = 1'b0;
    end
    o.err = ref_err; o.mdr = ref_mdr;
    exp_out.push_back(o);
    tick;
    quiet;
    check("err_cleared_on_request", 32'(err), 32'd0);
    if (d < TO) begin
      repeat (d) begin noise(nmode); tick; end
      quiet;
      mem_ack = 1'b1; mem_rdata = rdata;
      tick;
      mem_ack = 1'($urandom);
      mem_rdata = $urandom;
      noise(nmode);
      tick;
      mem_ack = 1'b0;
      quiet;
    end else begin
      repeat (TO) begin noise(nmode); tick; end
      quiet;
    end
    check("mar_after_txn", mar_out, 32'(ref_mar));
    check("mdr_after_txn", mdr_out, ref_mdr);
    check("err_after_txn", 32'(err), 32'(ref_err));
  endtask

  task automatic load_only(input bit lmar, input bit lmdr, input logic [31:0] bus);
    bus_mux_out = bus; mar_in = lmar; mdr_in = lmdr;
    if (lmar) ref_mar = bus[AW-1:0];
    if (lmdr) ref_mdr = bus;
    tick;
    quiet;
    check("load_mar_out", mar_out, 32'(ref_mar));
    check("load_mem_addr", 32'(mem_addr), 32'(ref_mar));
    check("load_mdr_out", mdr_out, ref_mdr);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_req"}, 32'(mem_req), 32'd0);
    check({tag, "_mem_we"},  32'(mem_we),  32'd0);
    check({tag, "_busy"},    32'(busy),    32'd0);
    check({tag, "_done"},    32'(done),    32'd0);
    check({tag, "_err"},     32'(err),     32'd0);
    check({tag, "_mar_out"}, mar_out,      32'd0);
    check({tag, "_mdr_out"}, mdr_out,      32'd0);
  endtask

  // Monitor: pairs each request start and end with the scoreboard
  bit req_prev = 1'b0;
  int req_cyc  = 0;
  bit pend_done = 1'b0;

  always @(negedge clk) begin
    req_t r;
    out_t o;
    if (pend_done) begin
      check("done_pulse", 32'(done), 32'd1);
      pend_done = 1'b0;
    end else if (done === 1'b1) begin
      check("done_unexpected", 32'(done), 32'd0);
    end
    if (mem_req === 1'b1 && !req_prev) begin
      if (exp_req.size() == 0) begin
        check("req_without_expectation", 32'(mem_req), 32'd0);
      end else begin
        r = exp_req.pop_front();
        check("req_mem_addr",  32'(mem_addr), 32'(r.addr));
        check("req_mar_out",   mar_out,       32'(r.addr));
        check("req_mem_we",    32'(mem_we),   32'(r.we));
        check("req_mem_wdata", mem_wdata,     r.wdata);
        check("req_busy",      32'(busy),     32'd1);
      end
      req_cyc = 0;
    end
    if (mem_req === 1'b1) req_cyc++;
    if (mem_req === 1'b0 && req_prev) begin
      if (exp_out.size() == 0) begin
        check("end_without_expectation", 32'(mem_req), 32'd1);
      end else begin
        o = exp_out.pop_front();
        check("req_length",   32'(req_cyc), 32'(o.cycles));
        check("end_err",      32'(err),     32'(o.err));
        check("end_mdr_out",  mdr_out,      o.mdr);
        check("end_busy",     32'(busy),    32'(o.busy));
        if (o.ok) pend_done = 1'b1;
      end
    end
    req_prev = (mem_req === 1'b1);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d;
    bit rd, wr;
    out_t o;
    req_t r;
    clr = 1'b0;
    bus_mux_out = 32'hFFFF_FFFF;
    quiet;
    mem_ack = 1'b1;
    mem_rdata = 32'hA5A5_A5A5;
    ref_mar = '0; ref_mdr = '0; ref_err = 1'b0;
    tick;
    tick;
    check_reset_outputs("reset");
    clr = 1'b1;
    mem_ack = 1'b0;
    tick;

    // Write with ack on the third REQ cycle
    load_only(1'b1, 1'b0, 32'h0000_0005);
    load_only(1'b0, 1'b1, 32'hDEAD_BEEF);
    txn(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 2, 32'h1111_2222, 0);
    check("write_keeps_mdr", mdr_out, 32'hDEAD_BEEF);

    // Read at top address, acked on the first REQ cycle
    load_only(1'b1, 1'b0, 32'h0000_01FF);
    txn(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 0, 32'h1234_5678, 0);
    tick;

    // Unacked read times out; the following request clears err
    txn(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, TO, 32'h0, 0);
    check("timeout_err_set", 32'(err), 32'd1);
    txn(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1, 32'h0, 0);

    // Read wins over write; MAR load attempts while busy are ignored
    txn(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0033, 4, 32'hCAFE_F00D, 2);
    check("busy_mar_unchanged", mar_out, 32'h0000_0033);

    // Upper bus bits are discarded on MAR load
    load_only(1'b1, 1'b0, 32'hFFFF_FE07);
    check("mar_zero_extend", mar_out, 32'h0000_0007);

    // Ack on the terminal timeout cycle still succeeds
    txn(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, TO - 1, 32'h0BAD_CAFE, 0);

    // Same-cycle load and request uses the new MAR/MDR
    txn(1'b1, 1'b1, 1'b0, 1'b1, 32'h7654_3021, 0, 32'h0, 0);

    // Randomized traffic with spurious acks and ignored control noise
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 4) == 0)
        load_only(1'($urandom), 1'($urandom), $urandom);
      do begin
        rd = 1'($urandom); wr = 1'($urandom);
      end while (!rd && !wr);
      d = $urandom_range(0, TO + 3);
      txn(1'($urandom), 1'($urandom), rd, wr, $urandom, d, $urandom, 1);
      repeat ($urandom_range(0, 2)) begin
        mem_ack = 1'($urandom);
        tick;
      end
      mem_ack = 1'b0;
    end

    // Reset during REQ with a coincident ack aborts the transaction
    tick;
    load_only(1'b1, 1'b1, 32'h1357_9BDF);
    bus_mux_out = 32'h0; mem_rd = 1'b1;
    r.addr = ref_mar; r.we = 1'b0; r.wdata = ref_mdr;
    exp_req.push_back(r);
    o.cycles = 2; o.ok = 1'b0; o.err = 1'b0; o.busy = 1'b0; o.mdr = 32'h0;
    exp_out.push_back(o);
    tick;
    quiet;
    tick;
    clr = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 32'hFEED_FACE;
    tick;
    clr = 1'b1;
    mem_ack = 1'b0;
    check_reset_outputs("abort");
    ref_mar = '0; ref_mdr = '0; ref_err = 1'b0;
    repeat (4) tick;

    check("scoreboard_req_drained", 32'(exp_req.size()), 32'd0);
    check("scoreboard_out_drained", 32'(exp_out.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
